// File: rtl/alu_pkg.sv
// Shared ALU encodings and the multiply sequencer state type.
// Every block that drives the shared ALU imports this package.
package alu_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_ANDB  = 2'b01;
  localparam logic [1:0] ALU_XOR   = 2'b10;
  localparam logic [1:0] ALU_SHIFT = 2'b11;

  localparam logic [1:0] BR_ZERO  = 2'b00;
  localparam logic [1:0] BR_NEG   = 2'b01;
  localparam logic [1:0] BR_CARRY = 2'b10;
  localparam logic [1:0] BR_OVF   = 2'b11;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_PP   = 2'd1,
    MS_ACC  = 2'd2,
    MS_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul_seq.sv
// 8x8 unsigned shift-and-add multiplier that borrows the core's shared ALU
// for the partial-product AND and the accumulate add, one bit per PP/ACC pair.
module mul_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] product,
  input  logic        flush,
  output logic        alu_own,
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  output logic [1:0]  alu_op,
  output logic        alu_sub,
  output logic        alu_branch,
  output logic        alu_shift_left,
  output logic [1:0]  alu_branch_sel,
  input  logic [7:0]  alu_result
);

  mul_state_e state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] mcand_reg, mcand_next;
  logic [7:0] mplier_reg, mplier_next;
  logic [7:0] hi_reg, hi_next;
  logic [7:0] pp_reg, pp_next;
  logic       carry;

  // The shared ALU has no carry-out port, so recover it from wraparound.
  assign carry = (alu_result < hi_reg);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    hi_next     = hi_reg;
    pp_next     = pp_reg;
    if (flush) begin
      state_next = MS_IDLE;
    end else begin
      case (state_reg)
        MS_IDLE: begin
          if (req_valid) begin
            mcand_next  = op_a;
            mplier_next = op_b;
            hi_next     = 8'd0;
            cnt_next    = 3'd0;
            state_next  = MS_PP;
          end
        end
        MS_PP: begin
          pp_next    = alu_result;
          state_next = MS_ACC;
        end
        MS_ACC: begin
          // Low product bits shift into the vacated top of the multiplier.
          hi_next     = {carry, alu_result[7:1]};
          mplier_next = {alu_result[0], mplier_reg[7:1]};
          cnt_next    = cnt_reg + 3'd1;
          state_next  = (cnt_reg == 3'd7) ? MS_DONE : MS_PP;
        end
        MS_DONE: begin
          if (rsp_ready) state_next = MS_IDLE;
        end
        default: state_next = MS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= MS_IDLE;
      cnt_reg    <= 3'd0;
      mcand_reg  <= 8'd0;
      mplier_reg <= 8'd0;
      hi_reg     <= 8'd0;
      pp_reg     <= 8'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      hi_reg     <= hi_next;
      pp_reg     <= pp_next;
    end
  end

  assign req_ready = (state_reg == MS_IDLE);
  assign rsp_valid = (state_reg == MS_DONE);
  assign product   = (state_reg == MS_DONE) ? {hi_reg, mplier_reg} : 16'd0;

  assign alu_own = (state_reg == MS_PP) || (state_reg == MS_ACC);
  assign alu_op  = (state_reg == MS_PP) ? ALU_ANDB : ALU_ADD;

  always_comb begin
    alu_in1 = 8'd0;
    alu_in2 = 8'd0;
    case (state_reg)
      MS_PP: begin
        alu_in1 = mcand_reg;
        alu_in2 = {7'd0, mplier_reg[0]};
      end
      MS_ACC: begin
        alu_in1 = hi_reg;
        alu_in2 = pp_reg;
      end
      default: begin
        alu_in1 = 8'd0;
        alu_in2 = 8'd0;
      end
    endcase
  end

  // Subtract, branch-flag and shifter paths are never used by this sequencer.
  assign alu_sub        = 1'b0;
  assign alu_branch     = 1'b0;
  assign alu_shift_left = 1'b0;
  assign alu_branch_sel = BR_ZERO;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq driving a behavioural model of the shared ALU, with a
// product scoreboard filled on accept and drained on the response handshake.
module tb_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] product;
  logic        flush;
  logic        alu_own;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_in2;
  logic [1:0]  alu_op;
  logic        alu_sub;
  logic        alu_branch;
  logic        alu_shift_left;
  logic [1:0]  alu_branch_sel;
  logic [7:0]  alu_result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .product(product), .flush(flush),
    .alu_own(alu_own), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .alu_sub(alu_sub), .alu_branch(alu_branch),
    .alu_shift_left(alu_shift_left), .alu_branch_sel(alu_branch_sel),
    .alu_result(alu_result)
  );

  // Shared ALU: ANDB gates in1 with the broadcast of in2[0].
  always_comb begin
    alu_result = 8'd0;
    case (alu_op)
      ALU_ADD:   alu_result = alu_sub ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);
      ALU_ANDB:  alu_result = alu_in1 & {8{alu_in2[0]}};
      ALU_XOR:   alu_result = alu_in1 ^ alu_in2;
      ALU_SHIFT: alu_result = alu_shift_left ? (alu_in1 << alu_in2[2:0]) : (alu_in1 >> alu_in2[2:0]);
      default:   alu_result = 8'd0;
    endcase
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: inputs change just after posedge, so negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check_val("rsp_unexpected", 16'(rsp_valid), 16'd0);
        else check_val("product", product, exp_q.pop_front());
      end
      if (req_valid && req_ready) exp_q.push_back(16'(op_a) * 16'(op_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first PP cycle.
  task automatic start(input logic [7:0] a, input logic [7:0] b);
    op_a = a;
    op_b = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(inout int n);
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int n = 0;
    start(a, b);
    wait_rsp(n);
    check_val("latency", 16'(n), 16'd17);
    check_val("product_direct", product, exp);
    tick();
  endtask

  task automatic count_rsp(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
  endtask

  initial begin
    int n;
    int hits;
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    flush = 1'b0;
    op_a = 8'd0;
    op_b = 8'd0;

    @(negedge clk);
    @(negedge clk);
    check_val("rst_req_ready", 16'(req_ready), 16'd1);
    check_val("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check_val("rst_alu_own", 16'(alu_own), 16'd0);
    check_val("rst_product", product, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 13 x 11 with a look at the ALU drive in the first PP and ACC cycles.
    start(8'd13, 8'd11);
    @(negedge clk);
    check_val("pp_alu_own", 16'(alu_own), 16'd1);
    check_val("pp_alu_op", 16'(alu_op), 16'(ALU_ANDB));
    check_val("pp_alu_in1", 16'(alu_in1), 16'd13);
    check_val("pp_alu_in2", 16'(alu_in2), 16'd1);
    @(negedge clk);
    check_val("acc_alu_op", 16'(alu_op), 16'(ALU_ADD));
    check_val("acc_alu_in1", 16'(alu_in1), 16'd0);
    check_val("acc_alu_in2", 16'(alu_in2), 16'd13);
    check_val("acc_alu_ctl", 16'({alu_sub, alu_branch, alu_shift_left, alu_branch_sel}), 16'd0);
    n = 2;
    wait_rsp(n);
    check_val("latency", 16'(n), 16'd17);
    check_val("product_direct", product, 16'h008F);
    check_val("done_req_ready", 16'(req_ready), 16'd0);
    check_val("done_alu_in1", 16'(alu_in1), 16'd0);
    tick();

    run_op(8'd255, 8'd255, 16'hFE01);
    run_op(8'd0,   8'd200, 16'h0000);
    run_op(8'd200, 8'd1,   16'h00C8);

    // Consumer stalls in DONE; an offered request meanwhile must be ignored.
    rsp_ready = 1'b0;
    start(8'd7, 8'd9);
    n = 1;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      check_val("hold_rsp_valid", 16'(rsp_valid), 16'd1);
      check_val("hold_product", product, 16'd63);
      check_val("hold_alu_own", 16'(alu_own), 16'd0);
      tick();
      if (i == 1) begin
        op_a = 8'd3;
        op_b = 8'd3;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check_val("post_hold_alu_own", 16'(alu_own), 16'd0);
    check_val("post_hold_req_ready", 16'(req_ready), 16'd1);
    tick();

    // Flush in cycle 6 of an operation.
    start(8'd50, 8'd60);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_req_ready", 16'(req_ready), 16'd1);
    check_val("flush_alu_own", 16'(alu_own), 16'd0);
    count_rsp(25, hits);
    check_val("flush_no_rsp", 16'(hits), 16'd0);
    tick();

    // Asynchronous reset in cycle 9 of a second operation.
    start(8'd9, 8'd9);
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check_val("arst_req_ready", 16'(req_ready), 16'd1);
    check_val("arst_alu_own", 16'(alu_own), 16'd0);
    check_val("arst_product", product, 16'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    count_rsp(25, hits);
    check_val("arst_no_rsp", 16'(hits), 16'd0);
    tick();

    // Back-to-back random traffic with the consumer always ready.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      n = 1;
      @(negedge clk);
      while (!req_ready && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (i > 0) check_val("b2b_gap", 16'(n), 16'd18);
      tick();
    end
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
